traffic_light_multi: RTL and testbench

//  Parametrised N-approach traffic-light controller; next generation of the single-approach traffic_light.

---
 rtl/traffic_pkg.sv | 16 +
 rtl/traffic_light_multi_prescaler.sv | 26 ++
 rtl/traffic_light_multi.sv | 156 +++++++++++++++
 tb/tb_traffic_light_multi.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared state encoding for the multi-approach traffic-light controller.
package traffic_pkg;
  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_ALL_RED = 2'd0;
  localparam logic [STATE_W-1:0] ST_GREEN   = 2'd1;
  localparam logic [STATE_W-1:0] ST_YELLOW  = 2'd2;
  localparam logic [STATE_W-1:0] ST_WALK    = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    S_ALL_RED = ST_ALL_RED,
    S_GREEN   = ST_GREEN,
    S_YELLOW  = ST_YELLOW,
    S_WALK    = ST_WALK
  } state_e;
endpackage

// File: rtl/traffic_light_multi_prescaler.sv
// Clock prescaler: one-cycle tick every TICK_DIV enabled clk cycles; frozen while en=0.
module tick_prescaler #(
  parameter int TICK_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == PW'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (tick)    cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/traffic_light_multi.sv
// Round-robin N-approach traffic-light controller (green -> yellow -> all-red per approach).
// Optional pedestrian walk phase enabled by macro TRAFFIC_PED_EN.
module traffic_light_multi
  import traffic_pkg::*;
#(
  parameter int NUM_DIR      = 3,
  parameter int TICK_DIV     = 10,
  parameter int CNT_W        = 8,
  parameter int GREEN_TICKS  = 30,
  parameter int YELLOW_TICKS = 5,
  parameter int ALLRED_TICKS = 2,
  parameter int WALK_TICKS   = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  output logic [NUM_DIR-1:0]         red_light,
  output logic [NUM_DIR-1:0]         yellow_light,
  output logic [NUM_DIR-1:0]         green_light,
`ifdef TRAFFIC_PED_EN
  input  logic                       ped_req,
  output logic                       walk_light,
`endif
  output logic [$clog2(NUM_DIR)-1:0] active_dir
);
  localparam int DIR_W = $clog2(NUM_DIR);
  localparam int MAXD  = 1 << CNT_W;

  if (NUM_DIR < 2) begin : g_chk_dir
    $error("NUM_DIR must be >= 2");
  end
  if (TICK_DIV < 1) begin : g_chk_div
    $error("TICK_DIV must be >= 1");
  end
  if (GREEN_TICKS < 1 || YELLOW_TICKS < 1 || ALLRED_TICKS < 1 || WALK_TICKS < 1) begin : g_chk_min
    $error("phase durations must be >= 1");
  end
  if (GREEN_TICKS >= MAXD || YELLOW_TICKS >= MAXD || ALLRED_TICKS >= MAXD || WALK_TICKS >= MAXD)
  begin : g_chk_max
    $error("phase durations must fit CNT_W");
  end

  logic tick;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .tick(tick)
  );

  state_e             state_q, state_d;
  logic [DIR_W-1:0]   dir_q, dir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_DIR-1:0] red_q, red_d, yel_q, yel_d, grn_q, grn_d;
`ifdef TRAFFIC_PED_EN
  logic               ped_q, ped_d, walk_q, walk_d;
`endif

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
`ifdef TRAFFIC_PED_EN
    ped_d   = ped_q | (en && ped_req && state_q != S_WALK);
`endif
    if (tick) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        case (state_q)
          S_ALL_RED: begin
`ifdef TRAFFIC_PED_EN
            if (ped_q) begin
              state_d = S_WALK;
              cnt_d   = CNT_W'(WALK_TICKS - 1);
              ped_d   = 1'b0;
            end else begin
              state_d = S_GREEN;
              cnt_d   = CNT_W'(GREEN_TICKS - 1);
            end
`else
            state_d = S_GREEN;
            cnt_d   = CNT_W'(GREEN_TICKS - 1);
`endif
          end
          S_GREEN: begin
            state_d = S_YELLOW;
            cnt_d   = CNT_W'(YELLOW_TICKS - 1);
          end
          S_YELLOW: begin
            state_d = S_ALL_RED;
            cnt_d   = CNT_W'(ALLRED_TICKS - 1);
            dir_d   = (dir_q == DIR_W'(NUM_DIR - 1)) ? '0 : dir_q + 1'b1;
          end
`ifdef TRAFFIC_PED_EN
          S_WALK: begin
            state_d = S_GREEN;
            cnt_d   = CNT_W'(GREEN_TICKS - 1);
          end
`endif
          default: begin
            state_d = S_ALL_RED;
            cnt_d   = CNT_W'(ALLRED_TICKS - 1);
          end
        endcase
      end
    end

    // Lamps decode the next state so they change on the same edge as the FSM.
    grn_d = '0;
    yel_d = '0;
    for (int d = 0; d < NUM_DIR; d++) begin
      grn_d[d] = (state_d == S_GREEN)  && (dir_d == DIR_W'(d));
      yel_d[d] = (state_d == S_YELLOW) && (dir_d == DIR_W'(d));
    end
    red_d = ~(grn_d | yel_d);
`ifdef TRAFFIC_PED_EN
    walk_d = (state_d == S_WALK);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_ALL_RED;
      dir_q   <= '0;
      cnt_q   <= CNT_W'(ALLRED_TICKS - 1);
      red_q   <= '1;
      yel_q   <= '0;
      grn_q   <= '0;
`ifdef TRAFFIC_PED_EN
      ped_q   <= 1'b0;
      walk_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      red_q   <= red_d;
      yel_q   <= yel_d;
      grn_q   <= grn_d;
`ifdef TRAFFIC_PED_EN
      ped_q   <= ped_d;
      walk_q  <= walk_d;
`endif
    end
  end

  assign red_light    = red_q;
  assign yellow_light = yel_q;
  assign green_light  = grn_q;
  assign active_dir   = dir_q;
`ifdef TRAFFIC_PED_EN
  assign walk_light   = walk_q;
`endif
endmodule

// File: tb/tb_traffic_light_multi.sv
// Directed scoreboard bench for traffic_light_multi (NUM_DIR=3, TICK_DIV=2).
module tb_traffic_light_multi;
  logic       clk, rst, en, ped_req;
  logic [2:0] red_light, yellow_light, green_light;
  logic [1:0] active_dir;
  logic       walk_obs;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    logic [2:0] red, yel, grn;
    logic [1:0] dir;
    logic       walk;
  } exp_t;

  exp_t sb[$];

  traffic_light_multi #(
    .NUM_DIR(3), .TICK_DIV(2), .CNT_W(8),
    .GREEN_TICKS(3), .YELLOW_TICKS(1), .ALLRED_TICKS(1), .WALK_TICKS(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .red_light   (red_light),
    .yellow_light(yellow_light),
    .green_light (green_light),
`ifdef TRAFFIC_PED_EN
    .ped_req     (ped_req),
    .walk_light  (walk_obs),
`endif
    .active_dir  (active_dir)
  );

`ifndef TRAFFIC_PED_EN
  assign walk_obs = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [2:0] grn, input logic [2:0] yel,
                      input logic [1:0] dir, input logic walk);
    exp_t e;
    e.tag  = tag;
    e.grn  = grn;
    e.yel  = yel;
    e.red  = ~(grn | yel);
    e.dir  = dir;
    e.walk = walk;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 4'd1, 4'd0);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".red"},   {1'b0, red_light},    {1'b0, e.red});
    chk({e.tag, ".yel"},   {1'b0, yellow_light}, {1'b0, e.yel});
    chk({e.tag, ".grn"},   {1'b0, green_light},  {1'b0, e.grn});
    chk({e.tag, ".dir"},   {2'b0, active_dir},   {2'b0, e.dir});
`ifdef TRAFFIC_PED_EN
    chk({e.tag, ".walk"},  {3'b0, walk_obs},     {3'b0, e.walk});
`endif
  endtask

  // Expect the given lamps after each of the next n rising edges.
  task automatic step(input string tag, input int n, input logic [2:0] grn,
                      input logic [2:0] yel, input logic [1:0] dir, input logic walk = 1'b0);
    for (int i = 0; i < n; i++) begin
      push(tag, grn, yel, dir, walk);
      @(posedge clk);
      #1;
      pop_check();
    end
  endtask

  // Safety invariant, every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      n_assert++;
      assert (($countones(~red_light) <= 1) && ((green_light & yellow_light) == 3'b000))
      else begin
        n_fail++;
        $error("FAIL invariant: red=%b yel=%b grn=%b required one non-red max, no grn&yel",
               red_light, yellow_light, green_light);
      end
    end
  end

  initial begin
    rst = 1'b1;
    en = 1'b0;
    ped_req = 1'b0;

    // 1: reset held with en low, then released with en still low
    step("rst_hold", 20, 3'b000, 3'b000, 2'd0);
    rst = 1'b0;
    step("en_low_idle", 5, 3'b000, 3'b000, 2'd0);

    // 2: free run through all approaches and wrap
    en = 1'b1;
    step("startup_red", 1, 3'b000, 3'b000, 2'd0);
    step("g0", 6, 3'b001, 3'b000, 2'd0);
    step("y0", 2, 3'b000, 3'b001, 2'd0);
    step("ar1", 2, 3'b000, 3'b000, 2'd1);
    step("g1", 6, 3'b010, 3'b000, 2'd1);
    step("y1", 2, 3'b000, 3'b010, 2'd1);
    step("ar2", 2, 3'b000, 3'b000, 2'd2);
    step("g2", 6, 3'b100, 3'b000, 2'd2);
    step("y2", 2, 3'b000, 3'b100, 2'd2);
    step("ar0_wrap", 2, 3'b000, 3'b000, 2'd0);
    step("g0_wrap", 6, 3'b001, 3'b000, 2'd0);
    step("y0_wrap", 2, 3'b000, 3'b001, 2'd0);
    step("ar1_b", 2, 3'b000, 3'b000, 2'd1);

    // 3: freeze mid-green[1], then exactly 3 more green cycles
    step("g1_pre", 3, 3'b010, 3'b000, 2'd1);
    en = 1'b0;
    step("g1_frozen", 7, 3'b010, 3'b000, 2'd1);
    en = 1'b1;
    step("g1_resume", 3, 3'b010, 3'b000, 2'd1);
    step("y1_after", 2, 3'b000, 3'b010, 2'd1);
    step("ar2_b", 2, 3'b000, 3'b000, 2'd2);
    step("g2_b", 6, 3'b100, 3'b000, 2'd2);
    step("y2_b", 1, 3'b000, 3'b100, 2'd2);

    // 4: async reset mid-yellow[2]
    rst = 1'b1;
    #1;
    push("rst_async", 3'b000, 3'b000, 2'd0, 1'b0);
    pop_check();
    step("rst_mid", 1, 3'b000, 3'b000, 2'd0);
    rst = 1'b0;
    step("restart_red", 1, 3'b000, 3'b000, 2'd0);
    step("restart_g0", 2, 3'b001, 3'b000, 2'd0);

    // 5: pedestrian request pulse during green[0]
    ped_req = 1'b1;
    step("g0_ped", 1, 3'b001, 3'b000, 2'd0);
    ped_req = 1'b0;
    step("g0_rest", 3, 3'b001, 3'b000, 2'd0);
    step("y0_c", 2, 3'b000, 3'b001, 2'd0);
    step("ar1_c", 2, 3'b000, 3'b000, 2'd1);
`ifdef TRAFFIC_PED_EN
    step("walk", 4, 3'b000, 3'b000, 2'd1, 1'b1);
`endif
    step("g1_c", 6, 3'b010, 3'b000, 2'd1);
    step("y1_c", 1, 3'b000, 3'b010, 2'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
